pulse_gen_ctrl: RTL and testbench



---
 rtl/pulse_gen_ctrl_if.sv | 11 +
 rtl/pulse_gen_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_pulse_gen_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_gen_ctrl_if.sv
// pulse_gen_ctrl_if: UART line pair between a host and the pulse generator.
//   RS232_Rx : host -> generator serial line, 8N1, idle high
//   RS232_Tx : generator -> host serial line, 8N1, idle high
//   master   : host side (drives RS232_Rx)
//   slave    : generator side (drives RS232_Tx)
interface pulse_gen_ctrl_if;
    logic RS232_Rx;
    logic RS232_Tx;
    modport master (output RS232_Rx, input RS232_Tx);
    modport slave (input RS232_Rx, output RS232_Tx);
endinterface

// File: rtl/pulse_gen_ctrl.sv
// pulse_gen_ctrl: UART-programmable two-pulse sequence generator.
//   clk_pll        : system clock, all logic on its rising edge
//   resetn         : synchronous active-low reset
//   clk            : board oscillator, pin compatibility only
//   uart           : RS232_Rx in / RS232_Tx out (5-byte write commands, 1-byte echo)
//   Pulse/P3/P4    : first|second pulse, first pulse, second pulse
//   Sync/P2/FM     : period marker, blanking window, CONTROL[2]
//   J1_4..J1_10    : debug taps; J4_3..J4_9 tied low
module pulse_gen_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_W = 50,
    parameter int BYTE_TIMEOUT = 1000000,
    parameter logic [31:0] PERIOD_INIT = 32'd100000
) (
    input  logic clk_pll,
    input  logic resetn,
    input  logic clk,
    pulse_gen_ctrl_if.slave uart,
    output logic Pulse,
    output logic Sync,
    output logic FM,
    output logic P2,
    output logic P3,
    output logic P4,
    output logic J1_4,
    output logic J1_5,
    output logic J1_6,
    output logic J1_7,
    output logic J1_8,
    output logic J1_9,
    output logic J1_10,
    output logic J4_3,
    output logic J4_4,
    output logic J4_5,
    output logic J4_6,
    output logic J4_7,
    output logic J4_8,
    output logic J4_9
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TIMEOUT = TW'(BYTE_TIMEOUT);
    localparam logic [31:0] SYNC_END = 32'(SYNC_W);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic unused_clk;
    assign unused_clk = clk;

    logic rx_meta, rx_sync, rx_prev, rx_valid;
    rx_state_t rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;

    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            rx_valid <= 1'b0;
            rx_state <= RX_IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta <= uart.RS232_Rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_sync) begin
                    rx_state <= RX_START;
                    rx_cnt <= '0;
                end
                // a start bit that is high again at mid-bit was a glitch
                RX_START: if (rx_cnt == HALF_LAST) begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                end else rx_cnt <= rx_cnt + 1'b1;
                RX_DATA: if (rx_cnt == BIT_LAST) begin
                    rx_cnt <= '0;
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                    rx_bit <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                end else rx_cnt <= rx_cnt + 1'b1;
                RX_STOP: if (rx_cnt == BIT_LAST) begin
                    rx_state <= RX_IDLE;
                    rx_valid <= rx_sync;
                end else rx_cnt <= rx_cnt + 1'b1;
            endcase
        end
    end

    logic [2:0] byte_cnt;
    logic [7:0] addr;
    logic [31:0] data;
    logic [TW-1:0] idle_cnt;
    logic cmd_done;

    // data bytes arrive LSB first, so shift each new byte in from the top
    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            byte_cnt <= '0;
            addr <= '0;
            data <= '0;
            idle_cnt <= '0;
            cmd_done <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            if (rx_valid) begin
                idle_cnt <= '0;
                if (byte_cnt == 3'd0) addr <= rx_shift;
                else data <= {rx_shift, data[31:8]};
                byte_cnt <= (byte_cnt == 3'd4) ? 3'd0 : byte_cnt + 1'b1;
                cmd_done <= (byte_cnt == 3'd4);
            end else if (byte_cnt != 3'd0) begin
                idle_cnt <= (idle_cnt == TIMEOUT) ? '0 : idle_cnt + 1'b1;
                if (idle_cnt == TIMEOUT) byte_cnt <= '0;
            end
        end
    end

    logic [31:0] period, p1w, delay, p2w, blank;
    logic en;

    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            period <= PERIOD_INIT;
            p1w <= 32'd30;
            delay <= 32'd200;
            p2w <= 32'd60;
            blank <= 32'd100;
            en <= 1'b1;
            FM <= 1'b0;
        end else if (cmd_done) begin
            case (addr)
                8'd0: period <= data;
                8'd1: p1w <= data;
                8'd2: delay <= data;
                8'd3: p2w <= data;
                8'd4: blank <= data;
                8'd5: begin
                    en <= data[0];
                    FM <= data[2];
                end
                default: ;
            endcase
        end
    end

    logic tx_busy, tx_line;
    logic [CW-1:0] tx_cnt;
    logic [3:0] tx_n;
    logic [8:0] tx_shift;

    // tx_shift carries data then the stop bit; echoes arriving while busy are dropped
    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
            tx_cnt <= '0;
            tx_n <= '0;
            tx_shift <= '1;
        end else if (!tx_busy) begin
            if (cmd_done) begin
                tx_busy <= 1'b1;
                tx_line <= 1'b0;
                tx_cnt <= '0;
                tx_n <= '0;
                tx_shift <= {1'b1, (addr <= 8'd5) ? addr : 8'hFF};
            end
        end else if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_n <= tx_n + 1'b1;
            if (tx_n == 4'd9) tx_busy <= 1'b0;
            else begin
                tx_line <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
            end
        end else tx_cnt <= tx_cnt + 1'b1;
    end

    assign uart.RS232_Tx = tx_line;

    logic [31:0] c, s_period, s_p1w, s_delay, s_p2w, s_blank;
    logic s_en;
    logic [31:0] cur_period, cur_p1w, cur_delay, cur_p2w, cur_blank;
    logic cur_en, run, p3_hit, p4_hit;
    logic [33:0] cc, p4_lo, p4_hi, p2_hi;

    // at c==0 the live registers are the values being latched, so use them directly
    always_comb begin
        cur_period = (c == 32'd0) ? period : s_period;
        cur_p1w = (c == 32'd0) ? p1w : s_p1w;
        cur_delay = (c == 32'd0) ? delay : s_delay;
        cur_p2w = (c == 32'd0) ? p2w : s_p2w;
        cur_blank = (c == 32'd0) ? blank : s_blank;
        cur_en = (c == 32'd0) ? en : s_en;
        run = cur_en && (cur_period != 32'd0);
        cc = {2'b00, c};
        p4_lo = {2'b00, cur_p1w} + {2'b00, cur_delay};
        p4_hi = p4_lo + {2'b00, cur_p2w};
        p2_hi = p4_hi + {2'b00, cur_blank};
        p3_hit = cc < {2'b00, cur_p1w};
        p4_hit = (cc >= p4_lo) && (cc < p4_hi);
    end

    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            c <= '0;
            s_period <= PERIOD_INIT;
            s_p1w <= 32'd30;
            s_delay <= 32'd200;
            s_p2w <= 32'd60;
            s_blank <= 32'd100;
            s_en <= 1'b1;
            Sync <= 1'b0;
            P3 <= 1'b0;
            P4 <= 1'b0;
            Pulse <= 1'b0;
            P2 <= 1'b0;
        end else begin
            s_period <= cur_period;
            s_p1w <= cur_p1w;
            s_delay <= cur_delay;
            s_p2w <= cur_p2w;
            s_blank <= cur_blank;
            s_en <= cur_en;
            c <= (!run || c == cur_period - 32'd1) ? 32'd0 : c + 32'd1;
            Sync <= run && (c < SYNC_END);
            P3 <= run && p3_hit;
            P4 <= run && p4_hit;
            Pulse <= run && (p3_hit || p4_hit);
            P2 <= run && (cc < p2_hi);
        end
    end

    assign J1_4 = rx_sync;
    assign J1_5 = Pulse;
    assign J1_6 = Sync;
    assign J1_7 = P2;
    assign J1_8 = tx_line;
    assign J1_9 = s_en;
    assign J1_10 = 1'b0;
    assign {J4_3, J4_4, J4_5, J4_6, J4_7, J4_8, J4_9} = '0;
endmodule

// File: tb/tb_pulse_gen_ctrl.sv
// tb_pulse_gen_ctrl: self-checking bench for pulse_gen_ctrl (scaled-down timing).
module tb_pulse_gen_ctrl;
    localparam int CPB = 16;
    localparam int SW = 5;
    localparam int TO = 300;
    localparam int PINIT = 3000;

    logic clk_pll = 1'b0, resetn = 1'b0, clk = 1'b0;
    logic Pulse, Sync, FM, P2, P3, P4;
    logic J1_4, J1_5, J1_6, J1_7, J1_8, J1_9, J1_10;
    logic J4_3, J4_4, J4_5, J4_6, J4_7, J4_8, J4_9;

    pulse_gen_ctrl_if uart();

    pulse_gen_ctrl #(
        .CLKS_PER_BIT(CPB),
        .SYNC_W(SW),
        .BYTE_TIMEOUT(TO),
        .PERIOD_INIT(32'(PINIT))
    ) dut (
        .clk_pll(clk_pll), .resetn(resetn), .clk(clk), .uart(uart),
        .Pulse(Pulse), .Sync(Sync), .FM(FM), .P2(P2), .P3(P3), .P4(P4),
        .J1_4(J1_4), .J1_5(J1_5), .J1_6(J1_6), .J1_7(J1_7), .J1_8(J1_8),
        .J1_9(J1_9), .J1_10(J1_10),
        .J4_3(J4_3), .J4_4(J4_4), .J4_5(J4_5), .J4_6(J4_6), .J4_7(J4_7),
        .J4_8(J4_8), .J4_9(J4_9)
    );

    always #5 clk_pll = ~clk_pll;
    always #21 clk = ~clk;

    int total = 0, bad = 0;
    logic [7:0] exp_q[$];
    int pr_period, pr_sync, pr_p3, pr_p4s, pr_p4, pr_p2, pr_map;
    int got[7], want[7];
    string fld[7] = '{"period", "sync_w", "p3_w", "p4_start", "p4_w", "p2_w", "map_err"};

    // Tx monitor: decodes each echo and pops the byte expected for it
    initial begin
        logic [7:0] b, e;
        logic ok;
        @(posedge resetn);
        forever begin
            @(negedge clk_pll);
            if (uart.RS232_Tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk_pll);
                ok = (uart.RS232_Tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_pll);
                    b[i] = uart.RS232_Tx;
                end
                repeat (CPB) @(negedge clk_pll);
                ok = ok && (uart.RS232_Tx === 1'b1);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL echo: got %h, no echo expected", b);
                end else begin
                    e = exp_q.pop_front();
                    if (!ok || b !== e) begin
                        bad++;
                        $display("FAIL echo: got %h (framing ok=%0d) expected %h", b, ok, e);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart.RS232_Rx = 1'b0;
        repeat (CPB) @(negedge clk_pll);
        for (int i = 0; i < 8; i++) begin
            uart.RS232_Rx = b[i];
            repeat (CPB) @(negedge clk_pll);
        end
        uart.RS232_Rx = stop;
        repeat (CPB) @(negedge clk_pll);
        uart.RS232_Rx = 1'b1;
        repeat (CPB) @(negedge clk_pll);
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back((a <= 8'd5) ? a : 8'hFF);
        send_byte(a, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
    endtask

    // measures one period from a Sync rise to the next; indices are cycles after the rise
    task automatic profile(input int bound);
        logic prev;
        bit found;
        pr_period = -1; pr_sync = 0; pr_p3 = 0; pr_p4s = -1; pr_p4 = 0; pr_p2 = 0; pr_map = 0;
        prev = Sync;
        found = 0;
        for (int n = 0; n < bound && !found; n++) begin
            @(negedge clk_pll);
            found = Sync && !prev;
            prev = Sync;
        end
        if (!found) return;
        for (int i = 0; i < bound; i++) begin
            pr_sync += int'(Sync);
            pr_p3 += int'(P3);
            pr_p4 += int'(P4);
            pr_p2 += int'(P2);
            if (P4 && pr_p4s < 0) pr_p4s = i;
            if (Pulse !== (P3 | P4) || J1_5 !== Pulse || J1_6 !== Sync || J1_7 !== P2 ||
                J1_8 !== uart.RS232_Tx || J1_10 !== 1'b0 ||
                {J4_3, J4_4, J4_5, J4_6, J4_7, J4_8, J4_9} !== 7'd0) pr_map++;
            prev = Sync;
            @(negedge clk_pll);
            if (Sync && !prev) begin
                pr_period = i + 1;
                break;
            end
        end
        got = '{pr_period, pr_sync, pr_p3, pr_p4s, pr_p4, pr_p2, pr_map};
    endtask

    task automatic test_reset();
        int viol = 0;
        resetn = 1'b0;
        uart.RS232_Rx = 1'b1;
        repeat (10) begin
            @(negedge clk_pll);
            if ({Sync, Pulse, P2, P3, P4, FM, J1_10} !== 7'd0 || uart.RS232_Tx !== 1'b1) viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL reset_outputs: %0d bad cycles, expected 0", viol);
        end
        resetn = 1'b1;
        profile(10000);
        want = '{3000, 5, 30, 230, 60, 390, 0};
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== want[i]) begin
                bad++;
                $display("FAIL reset_%s: got %0d expected %0d", fld[i], got[i], want[i]);
            end
        end
        total++;
        if ({J1_4, J1_9} !== 2'b11) begin
            bad++;
            $display("FAIL reset_debug: J1_4/J1_9 got %b expected 11", {J1_4, J1_9});
        end
    endtask

    task automatic test_p1w_write();
        repeat (2156) @(negedge clk_pll);
        fork
            send_cmd(8'h01, 32'd100);
        join_none
        profile(10000);
        want = '{3000, 5, 30, 230, 60, 390, 0};
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== want[i]) begin
                bad++;
                $display("FAIL p1w_cur_%s: got %0d expected %0d", fld[i], got[i], want[i]);
            end
        end
        profile(10000);
        want = '{3000, 5, 100, 300, 60, 460, 0};
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== want[i]) begin
                bad++;
                $display("FAIL p1w_next_%s: got %0d expected %0d", fld[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_disable();
        int viol = 0;
        send_cmd(8'h05, 32'd0);
        repeat (PINIT + 100) @(negedge clk_pll);
        repeat (400) begin
            @(negedge clk_pll);
            if ({Sync, Pulse, P2, P3, P4, J1_9, FM} !== 7'd0) viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL disabled_outputs: %0d bad cycles, expected 0", viol);
        end
        send_cmd(8'h05, 32'd5);
        total++;
        if ({FM, P3} !== 2'b11) begin
            bad++;
            $display("FAIL reenable: FM/P3 got %b expected 11", {FM, P3});
        end
        profile(10000);
        want = '{3000, 5, 100, 300, 60, 460, 0};
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== want[i]) begin
                bad++;
                $display("FAIL reenable_%s: got %0d expected %0d", fld[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_bad_addr_timeout();
        send_cmd(8'h09, 32'h44332211);
        send_byte(8'h02, 1'b1);
        repeat (TO + 200) @(negedge clk_pll);
        send_cmd(8'h03, 32'd40);
        profile(10000);
        want = '{3000, 5, 100, 300, 40, 440, 0};
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== want[i]) begin
                bad++;
                $display("FAIL timeout_%s: got %0d expected %0d", fld[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_short_period();
        send_cmd(8'h01, 32'd30);
        send_cmd(8'h03, 32'd60);
        send_cmd(8'h00, 32'd200);
        profile(10000);
        want = '{200, 5, 30, -1, 0, 200, 0};
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== want[i]) begin
                bad++;
                $display("FAIL short_%s: got %0d expected %0d", fld[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_bad_frames();
        send_byte(8'h01, 1'b0);
        uart.RS232_Rx = 1'b0;
        repeat (3) @(negedge clk_pll);
        uart.RS232_Rx = 1'b1;
        repeat (3 * CPB) @(negedge clk_pll);
        send_cmd(8'h00, 32'd300);
        profile(10000);
        want = '{300, 5, 30, 230, 60, 300, 0};
        for (int i = 0; i < 7; i++) begin
            total++;
            if (got[i] !== want[i]) begin
                bad++;
                $display("FAIL frames_%s: got %0d expected %0d", fld[i], got[i], want[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_p1w_write();
        test_disable();
        test_bad_addr_timeout();
        test_short_period();
        test_bad_frames();
        repeat (400) @(negedge clk_pll);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL echo_pending: %0d echoes missing, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
